// File: rtl/router_rx_nasyn_pkg.sv
// Shared router receive definitions.
// Holds the receiver FSM state encoding, the symbols-per-word helper and the
// legal parameter lists used to reject unsupported configurations.
package router_rx_nasyn_pkg;

  localparam int unsigned WordWidth = 128;
  localparam int unsigned CntWidth  = 5;  // covers pClkMult = 16
  localparam int unsigned SymWidth  = 7;  // covers 64 symbols

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  // Entry 0 is the lowest legal value.
  localparam logic [2:0][4:0] LegalBitsParallel = {5'd8, 5'd4, 5'd2};
  localparam logic [2:0][4:0] LegalClkMult      = {5'd16, 5'd8, 5'd4};

  // Data symbols per frame.
  function automatic int unsigned num_symbols(int unsigned bits_parallel);
    return WordWidth / bits_parallel;
  endfunction

  function automatic bit cfg_legal(int unsigned bits_parallel, int unsigned clk_mult);
    bit p_ok;
    bit m_ok;
    p_ok = 1'b0;
    m_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if ({27'b0, LegalBitsParallel[i]} == bits_parallel) p_ok = 1'b1;
      if ({27'b0, LegalClkMult[i]} == clk_mult) m_ok = 1'b1;
    end
    return p_ok && m_ok;
  endfunction

endpackage

// File: rtl/router_sync2.sv
// Two-flop synchronizer for a bus of independent asynchronous lines.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - synchronized output, two clk_i cycles behind d_i
module router_sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Resets to zero so a downstream idle detector never sees a fake idle line
  // straight out of reset; real ones must propagate through both flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/router_rx_nasyn.sv
// Nibble-parallel router frame receiver with a WISHBONE read port.
// A frame is one all-zero start symbol, 128/pBitsParallel data symbols
// (LSB first) and one all-ones stop symbol; the line idles at all ones.
// Ports:
//   clk_i, rst_i          - clock (also the oversampling clock), async active-low reset
//   cs_i, cyc_i, stb_i    - WISHBONE select / cycle / strobe
//   we_i                  - write; writes are acked and ignored
//   adr_i                 - 0: data register, 1: status {frame_err, overrun, full}
//   ack_o                 - combinational acknowledge
//   dat_o                 - read data
//   rxd                   - asynchronous serial line
//   rts                   - registered ~full, throttles the far transmitter
//   full                  - a received word is waiting to be read
module router_rx_nasyn
  import router_rx_nasyn_pkg::*;
#(
  parameter int unsigned pBitsParallel = 4,
  parameter int unsigned pClkMult      = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cs_i,
  input  logic                     cyc_i,
  input  logic                     stb_i,
  input  logic                     we_i,
  input  logic                     adr_i,
  output logic                     ack_o,
  output logic [WordWidth-1:0]     dat_o,
  input  logic [pBitsParallel-1:0] rxd,
  output logic                     rts,
  output logic                     full
);

  if (!cfg_legal(pBitsParallel, pClkMult)) begin : g_bad_cfg
    $error("router_rx_nasyn: unsupported pBitsParallel/pClkMult");
  end

  localparam int unsigned          NumSym   = num_symbols(pBitsParallel);
  localparam logic [CntWidth-1:0]  HalfLast = CntWidth'(pClkMult / 2 - 1);
  localparam logic [CntWidth-1:0]  FullLast = CntWidth'(pClkMult - 1);
  localparam logic [SymWidth-1:0]  SymLast  = SymWidth'(NumSym - 1);

  logic [pBitsParallel-1:0] rs;

  router_sync2 #(
    .Width (pBitsParallel)
  ) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_i),
    .d_i    (rxd),
    .q_o    (rs)
  );

  rx_state_e            state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [SymWidth-1:0]  sym_q, sym_d;
  logic [WordWidth-1:0] shift_q, shift_d;
  logic [WordWidth-1:0] data_q, data_d;
  logic                 full_q, full_d;
  logic                 overrun_q, overrun_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rts_q;

  logic data_read, status_read;
  logic load, ovr_set, ferr_set;

  assign ack_o       = cyc_i & stb_i & cs_i;
  assign data_read   = ack_o & ~we_i & ~adr_i;
  assign status_read = ack_o & ~we_i & adr_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sym_d    = sym_q;
    shift_d  = shift_q;
    load     = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;

    unique case (state_q)
      StWaitIdle: begin
        if (rs == '1) state_d = StIdle;
      end
      StIdle: begin
        if (rs == '0) begin
          cnt_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HalfLast) begin
          if (rs == '0) begin
            cnt_d   = '0;
            sym_d   = '0;
            state_d = StData;
          end else begin
            state_d = StIdle;  // glitch, not a start symbol
          end
        end
      end
      StData: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FullLast) begin
          cnt_d   = '0;
          shift_d = {rs, shift_q[WordWidth-1:pBitsParallel]};
          sym_d   = sym_q + 1'b1;
          if (sym_q == SymLast) state_d = StStop;
        end
      end
      StStop: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FullLast) begin
          if (rs == '1) begin
            // A data read in this same cycle frees the register for the new word.
            if (!full_q || data_read) load = 1'b1;
            else                      ovr_set = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_set = 1'b1;
            state_d  = StWaitIdle;
          end
        end
      end
      default: state_d = StWaitIdle;
    endcase
  end

  // Clears from reads come first so a same-cycle set wins.
  always_comb begin
    data_d      = data_q;
    full_d      = full_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (data_read) full_d = 1'b0;
    if (status_read) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    if (load) begin
      data_d = shift_q;
      full_d = 1'b1;
    end
    if (ovr_set)  overrun_d   = 1'b1;
    if (ferr_set) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= StWaitIdle;
      cnt_q       <= '0;
      sym_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      full_q      <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rts_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      full_q      <= full_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rts_q       <= ~full_q;
    end
  end

  assign dat_o = adr_i ? {{(WordWidth - 3){1'b0}}, frame_err_q, overrun_q, full_q} : data_q;
  assign rts   = rts_q;
  assign full  = full_q;

endmodule

// File: tb/tb_router_rx_nasyn.sv
module tb_router_rx_nasyn;

  localparam int NI = 3;

  function automatic int p_of(input int i);
    case (i)
      0:       return 4;
      1:       return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int m_of(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      default: return 16;
    endcase
  endfunction

  // Cycles from the first cycle the start symbol is driven to the first cycle
  // full is visible: 2 sync cycles, then stop sample at M/2+(N+1)M, then +1.
  function automatic int eff_off(input int i);
    int m;
    int n;
    m = m_of(i);
    n = 128 / p_of(i);
    return 2 + m / 2 + (n + 1) * m + 1;
  endfunction

  typedef struct {
    int           eff;
    int           kind;  // 0 data read, 1 status read, 2 good frame, 3 bad stop
    logic [127:0] w;
  } ev_t;

  logic          clk;
  logic          rst_n;
  int            cyc = 0;
  logic [7:0]    line [NI];
  logic [NI-1:0] wb_cs, wb_cyc, wb_stb, wb_we, wb_adr;
  logic [NI-1:0] ack_w, rts_w, full_w;
  logic [127:0]  dat_w [NI];

  int total = 0;
  int bad   = 0;

  // Model state
  logic [NI-1:0] m_full, m_ovr, m_ferr, m_fprev, seen_full;
  logic [127:0]  m_data [NI];
  ev_t           rdq [NI][$];
  ev_t           frq [NI][$];
  int            rise [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GP = p_of(g);
    localparam int GM = m_of(g);
    router_rx_nasyn #(
      .pBitsParallel (GP),
      .pClkMult      (GM)
    ) u_dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .cs_i  (wb_cs[g]),
      .cyc_i (wb_cyc[g]),
      .stb_i (wb_stb[g]),
      .we_i  (wb_we[g]),
      .adr_i (wb_adr[g]),
      .ack_o (ack_w[g]),
      .dat_o (dat_w[g]),
      .rxd   (line[g][GP-1:0]),
      .rts   (rts_w[g]),
      .full  (full_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int i, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %h want %h", nm, i, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_full    = '0;
    m_ovr     = '0;
    m_ferr    = '0;
    m_fprev   = '0;
    seen_full = '0;
    for (int i = 0; i < NI; i++) begin
      m_data[i] = '0;
      rdq[i].delete();
      frq[i].delete();
      rise[i] = -1;
    end
  endtask

  // Compare process: apply due model events (reads before frame completions),
  // then check every output of every instance.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n) begin
      for (int i = 0; i < NI; i++) begin
        while (rdq[i].size() > 0 && rdq[i][0].eff <= cyc) begin
          e = rdq[i].pop_front();
          if (e.kind == 0) m_full[i] = 1'b0;
          else begin
            m_ovr[i]  = 1'b0;
            m_ferr[i] = 1'b0;
          end
        end
        while (frq[i].size() > 0 && frq[i][0].eff <= cyc) begin
          e = frq[i].pop_front();
          if (e.kind == 3) m_ferr[i] = 1'b1;
          else if (!m_full[i]) begin
            m_full[i] = 1'b1;
            m_data[i] = e.w;
          end else m_ovr[i] = 1'b1;
        end
        chk("full", i, 128'(full_w[i]), 128'(m_full[i]));
        chk("rts", i, 128'(rts_w[i]), 128'(!m_fprev[i]));
        chk("ack", i, 128'(ack_w[i]), 128'(wb_cs[i] & wb_cyc[i] & wb_stb[i]));
        if (wb_adr[i]) chk("status", i, dat_w[i], {125'b0, m_ferr[i], m_ovr[i], m_full[i]});
        else           chk("data", i, dat_w[i], m_data[i]);
        m_fprev[i] = m_full[i];
        if (full_w[i] && !seen_full[i]) rise[i] = cyc;
        seen_full[i] = full_w[i];
      end
    end
  end

  // One WISHBONE cycle; entered and left just after a rising edge.
  task automatic wb(input int i, input logic cs, input logic we, input logic adr,
                    output logic [127:0] d);
    ev_t e;
    wb_cs[i]  = cs;
    wb_cyc[i] = 1'b1;
    wb_stb[i] = 1'b1;
    wb_we[i]  = we;
    wb_adr[i] = adr;
    @(negedge clk);
    d = dat_w[i];
    if (cs && !we) begin
      e.eff  = cyc + 1;
      e.kind = adr ? 1 : 0;
      e.w    = '0;
      rdq[i].push_back(e);
    end
    step(1);
    wb_cs[i]  = 1'b0;
    wb_cyc[i] = 1'b0;
    wb_stb[i] = 1'b0;
    wb_we[i]  = 1'b0;
    wb_adr[i] = 1'b0;
  endtask

  // Drives a full frame (or only its first max_cyc cycles when max_cyc > 0).
  task automatic send_frame(input int i, input logic [127:0] w, input logic [7:0] stop,
                            input int max_cyc, output int c0);
    int         p, m, n, cnt;
    logic [7:0] mask, sym;
    ev_t        e;
    p    = p_of(i);
    m    = m_of(i);
    n    = 128 / p;
    mask = 8'((1 << p) - 1);
    c0   = cyc;
    cnt  = 0;
    e.eff  = c0 + eff_off(i);
    e.kind = ((stop & mask) == mask) ? 2 : 3;
    e.w    = w;
    frq[i].push_back(e);
    for (int k = -1; k <= n; k++) begin
      if (k < 0)       sym = 8'h00;
      else if (k == n) sym = stop;
      else             sym = 8'((w >> (k * p)) & 128'(mask));
      for (int j = 0; j < m; j++) begin
        if (max_cyc > 0 && cnt == max_cyc) return;
        line[i] = sym;
        step(1);
        cnt++;
      end
    end
    line[i] = 8'hFF;
  endtask

  localparam logic [127:0] W1  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] W2  = 128'hDEAD_BEEF_0000_1111_2222_3333_CAFE_F00D;
  localparam logic [127:0] W3  = 128'h5555_AAAA_5555_AAAA_1234_5678_9ABC_DEF0;
  localparam logic [127:0] W4  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [127:0] W5  = 128'h0000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] W6  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] W7  = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
  localparam logic [127:0] W8  = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_F0F0_3C3C_C3C3;
  localparam logic [127:0] W9  = 128'h0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD_0BAD;
  localparam logic [127:0] W10 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [127:0] W11 = 128'hC001_D00D_1357_9BDF_2468_ACE0_FACE_B00C;
  localparam logic [127:0] W12 = 128'h7E7E_8181_0123_4567_89AB_CDEF_0F1E_2D3C;

  initial begin
    logic [127:0] d;
    int           c0, ct;
    rst_n  = 1'b0;
    wb_cs  = '0;
    wb_cyc = '0;
    wb_stb = '0;
    wb_we  = '0;
    wb_adr = '0;
    for (int i = 0; i < NI; i++) line[i] = 8'hFF;
    model_reset();
    #12;
    chk("rst_full", 0, 128'(full_w[0]), 128'd0);
    chk("rst_rts", 0, 128'(rts_w[0]), 128'd1);
    chk("rst_dat", 0, dat_w[0], 128'd0);
    step(2);
    rst_n = 1'b1;
    step(4);

    // Clean frame
    send_frame(0, W1, 8'hFF, 0, c0);
    step(4);
    chk("latency_p4m4", 0, 128'(rise[0] - c0), 128'd137);
    wb(0, 1'b1, 1'b0, 1'b0, d);
    chk("read_w1", 0, d, W1);
    step(2);
    chk("post_read_full", 0, 128'(full_w[0]), 128'd0);
    chk("post_read_rts", 0, 128'(rts_w[0]), 128'd1);

    // Glitch then a valid frame
    line[0] = 8'h00;
    step(1);
    line[0] = 8'hFF;
    step(12);
    chk("glitch_full", 0, 128'(full_w[0]), 128'd0);
    send_frame(0, W2, 8'hFF, 0, c0);
    step(4);
    wb(0, 1'b1, 1'b0, 1'b0, d);
    chk("read_w2", 0, d, W2);

    // Framing error
    send_frame(0, W3, 8'h07, 0, c0);
    step(4);
    wb(0, 1'b1, 1'b0, 1'b1, d);
    chk("ferr_status", 0, d, 128'h4);
    wb(0, 1'b1, 1'b0, 1'b1, d);
    chk("ferr_cleared", 0, d, 128'h0);
    wb(0, 1'b1, 1'b0, 1'b0, d);
    chk("ferr_keeps_word", 0, d, W2);

    // Overrun
    send_frame(0, W4, 8'hFF, 0, c0);
    step(4);
    send_frame(0, W5, 8'hFF, 0, c0);
    step(4);
    wb(0, 1'b1, 1'b0, 1'b1, d);
    chk("ovr_status", 0, d, 128'h3);
    wb(0, 1'b1, 1'b0, 1'b0, d);
    chk("ovr_first_word", 0, d, W4);
    wb(0, 1'b1, 1'b0, 1'b1, d);
    chk("ovr_cleared", 0, d, 128'h0);

    // Data read colliding with a frame completion
    send_frame(0, W6, 8'hFF, 0, c0);
    step(4);
    fork
      send_frame(0, W7, 8'hFF, 0, c0);
      begin
        ct = cyc + eff_off(0) - 1;
        while (cyc < ct) step(1);
        wb(0, 1'b1, 1'b0, 1'b0, d);
      end
    join
    chk("coll_old_word", 0, d, W6);
    step(2);
    chk("coll_full", 0, 128'(full_w[0]), 128'd1);
    wb(0, 1'b1, 1'b0, 1'b1, d);
    chk("coll_status", 0, d, 128'h1);
    // Writes and unselected reads leave state alone
    wb(0, 1'b1, 1'b1, 1'b0, d);
    wb(0, 1'b0, 1'b0, 1'b0, d);
    step(1);
    chk("ignored_full", 0, 128'(full_w[0]), 128'd1);
    wb(0, 1'b1, 1'b0, 1'b0, d);
    chk("coll_new_word", 0, d, W7);

    // Reset mid-DATA with a word pending
    send_frame(0, W8, 8'hFF, 0, c0);
    step(4);
    send_frame(0, W9, 8'hFF, 60, c0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst2_full", 0, 128'(full_w[0]), 128'd0);
    chk("rst2_rts", 0, 128'(rts_w[0]), 128'd1);
    chk("rst2_dat", 0, dat_w[0], 128'd0);
    wb_cs[0]  = 1'b1;
    wb_cyc[0] = 1'b1;
    wb_stb[0] = 1'b1;
    #1;
    chk("rst2_ack", 0, 128'(ack_w[0]), 128'd1);
    wb_cs[0]  = 1'b0;
    wb_cyc[0] = 1'b0;
    wb_stb[0] = 1'b0;
    line[0]   = 8'h00;
    step(2);
    rst_n = 1'b1;
    step(160);
    wb(0, 1'b1, 1'b0, 1'b1, d);
    chk("rst2_no_frame", 0, d, 128'h0);
    line[0] = 8'hFF;
    step(4);
    send_frame(0, W10, 8'hFF, 0, c0);
    step(4);
    wb(0, 1'b1, 1'b0, 1'b0, d);
    chk("read_w10", 0, d, W10);

    // Parameter sweep
    send_frame(1, W11, 8'hFF, 0, c0);
    step(4);
    chk("latency_p2m8", 1, 128'(rise[1] - c0), 128'd527);
    wb(1, 1'b1, 1'b0, 1'b0, d);
    chk("read_p2m8", 1, d, W11);
    send_frame(2, W12, 8'hFF, 0, c0);
    step(4);
    chk("latency_p8m16", 2, 128'(rise[2] - c0), 128'd283);
    wb(2, 1'b1, 1'b0, 1'b0, d);
    chk("read_p8m16", 2, d, W12);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_rx_nasyn.md
# router_rx_nasyn

Nibble-parallel serial receiver that accepts 128-bit router frames from a byte-serial link transmitter. Each frame is an all-zero start symbol, 128 data bits sent LSB-first in pBitsParallel-wide symbols, then an all-ones stop symbol; the line idles at all ones. The block oversamples the link, reassembles the word, and presents it on a WISHBONE read port with full/overrun/framing status. It sits at the receive end of each router link, and its `rts` output drives the far transmitter's `cts`.

## Interface
- pBitsParallel, 4: symbol width in bits; legal values are 2, 4, 8.
- pClkMult, 4: clk_i cycles per symbol; legal values are 4, 8, 16.
- clk_i  in  1  sole clock; it also serves as the oversampling clock.
- rst_i  in  1  reset, asynchronous, active-low.
- cs_i, cyc_i, stb_i  in  1 each  WISHBONE select/cycle/strobe.
- we_i  in  1  write; write cycles are acked and ignored.
- adr_i  in  1  0 = data register, 1 = status register.
- ack_o  out  1  = cyc_i & stb_i & cs_i (combinational).
- dat_o  out  128  adr_i=0: received word; adr_i=1: {125'b0, frame_err, overrun, full}.
- rxd  in  pBitsParallel  serial line, asynchronous to clk_i.
- rts  out  1  registered, = ~full; low throttles the far transmitter.
- full  out  1  a received word is waiting to be read.

## Operation
- rxd passes through a 2-flop synchronizer; all decisions use the synchronized value `rs`.
- N = 128/pBitsParallel data symbols (64, 32 or 16).
- The state machine has five states:
  - WAIT_IDLE: the reset state. Go to IDLE once rs is all ones.
  - IDLE: when rs == 0 (all bits), clear the counter and go to START.
  - START: at counter == pClkMult/2-1 (mid-symbol), re-check rs. If rs == 0, clear the counter and symbol index and go to DATA. Otherwise it was a glitch; go to IDLE.
  - DATA: every pClkMult cycles, shift rs into the top of a 128-bit shift register (right-shift, LSB-first). After symbol N-1, go to STOP.
  - STOP: sample after one more pClkMult period.
- STOP outcomes:
  - rs all ones and full=0: load the data register, set full, go to IDLE.
  - rs all ones and full=1: discard the frame, keep the old word, set overrun, go to IDLE.
  - rs not all ones: set frame_err (sticky), discard the frame, go to WAIT_IDLE.
- Reads:
  - An acked read with adr_i=0 clears full at that clock edge.
  - An acked read with adr_i=1 clears overrun and frame_err.
- Simultaneous events:
  - A frame completing in the same cycle as a data read loads the new word and leaves full=1.
  - A status read in the same cycle as a new overrun or frame_err leaves that flag set.
- Reset asserted mid-frame aborts the frame immediately. The next frame is accepted only after the line has been seen idle.

## Timing
- Reset values:
  - ack_o follows its inputs.
  - full=0, rts=1, overrun=0, frame_err=0, dat_o=0.
  - Data register = 0; state = WAIT_IDLE.
- Let t0 be the first cycle in IDLE where rs == 0. Sample points are:
  - start verify at t0+pClkMult/2;
  - data symbol k at t0+pClkMult/2+(k+1)·pClkMult, for k = 0..N-1;
  - stop at t0+pClkMult/2+(N+1)·pClkMult.
- full and the data register update one cycle after the stop sample; rts falls one cycle after full rises.
- Example, P=4, M=4: stop sampled at t0+134, full at t0+135.
- rxd-to-rs latency is 2 cycles.
- The counter width is 5 bits, which covers pClkMult=16. The symbol index width is 7 bits.

## Structure
- Shared router defines include holds:
  - the state encodings (WAIT_IDLE, IDLE, START, DATA, STOP);
  - N as a function of pBitsParallel;
  - the legal-value lists for pBitsParallel and pClkMult.
- A separate sub-module, router_sync2, holds the 2-flop synchronizer, parameterized by width. It is reused by other link blocks.
- The state machine, shift register and WISHBONE logic stay in router_rx_nasyn.

## Test plan
- Clean frame: P=4, M=4, word 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 → full=1 at t0+135, a data read returns the exact word, full=0 and rts=1 afterwards.
- Glitch: rs=0 for 1 cycle, then all ones → machine returns to IDLE, no full; a following valid frame is received correctly.
- Framing error: stop symbol 4'h7 → frame_err=1, full stays 0, machine waits for idle; a status read returns 3'b100 and clears it.
- Overrun: two frames with no read between them → first word retained, status reads 3'b011.
- Read collision: a data read acked in the stop+1 cycle of a second frame → the new word is loaded and full stays 1.
- Reset: rst_i low mid-DATA → all outputs at reset values at once; with the line held at 0 after release, no frame starts until rs is all ones.
- Parameter sweep: repeat the clean-frame case for P ∈ {2, 8} and M ∈ {8, 16}.
